// File: rtl/rv_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : rv_control_unit
// Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for
//            the RV32I softcore. It classifies the decoded opcode, drives the
//            datapath strobes and selects, handshakes with instruction and
//            data memory, traps on illegal encodings and counts retirements.
// Revision : 1.0 - initial release
// ============================================================================
module rv_control_unit #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic                branch_taken_i,
  output logic                imem_req_o,
  input  logic                imem_ready_i,
  output logic                ir_we_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  input  logic                dmem_ready_i,
  output logic                alu_src_a_o,
  output logic                alu_src_b_o,
  output logic [2:0]          imm_sel_o,
  output logic                rf_we_o,
  output logic [1:0]          wb_sel_o,
  output logic                pc_we_o,
  output logic [1:0]          pc_sel_o,
  output logic                trap_o,
  output logic [2:0]          state_o,
  output logic [RETIRE_W-1:0] retired_o
);

  // Major opcode encodings of the RV32I base set
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Immediate select codes
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Writeback source codes
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_UIMM = 2'b11;

  // Next-PC source codes
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd7
  } state_e;

  // Instruction class latched in DECODE; CL_NONE is the reset value
  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_LUI    = 4'd1,
    CL_AUIPC  = 4'd2,
    CL_JAL    = 4'd3,
    CL_JALR   = 4'd4,
    CL_BRANCH = 4'd5,
    CL_LOAD   = 4'd6,
    CL_STORE  = 4'd7,
    CL_OPIMM  = 4'd8,
    CL_OP     = 4'd9,
    CL_FENCE  = 4'd10
  } class_e;

  state_e                state_q, state_d;
  class_e                class_q, class_d;
  logic                  trap_q, trap_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;

  class_e                dec_class;
  logic                  dec_legal;

  // Classify the decoder fields and flag reserved funct3 combinations
  always_comb begin
    dec_class = CL_NONE;
    dec_legal = 1'b0;
    unique case (opcode_i)
      OPC_LUI:    begin dec_class = CL_LUI;    dec_legal = 1'b1; end
      OPC_AUIPC:  begin dec_class = CL_AUIPC;  dec_legal = 1'b1; end
      OPC_JAL:    begin dec_class = CL_JAL;    dec_legal = 1'b1; end
      OPC_JALR:   begin dec_class = CL_JALR;   dec_legal = (funct3_i == 3'b000); end
      OPC_BRANCH: begin
        dec_class = CL_BRANCH;
        dec_legal = (funct3_i != 3'b010) && (funct3_i != 3'b011);
      end
      OPC_LOAD:   begin
        dec_class = CL_LOAD;
        dec_legal = (funct3_i != 3'b011) && (funct3_i < 3'b110);
      end
      OPC_STORE:  begin dec_class = CL_STORE;  dec_legal = (funct3_i < 3'b011); end
      OPC_OPIMM:  begin dec_class = CL_OPIMM;  dec_legal = 1'b1; end
      OPC_OP:     begin dec_class = CL_OP;     dec_legal = 1'b1; end
      OPC_FENCE:  begin dec_class = CL_FENCE;  dec_legal = 1'b1; end
      default:    begin dec_class = CL_NONE;   dec_legal = 1'b0; end
    endcase
  end

  // Sequencer: next state, class latch, trap flag and handshake/strobe outputs
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    trap_d     = trap_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    wb_sel_o   = WB_ALU;
    pc_we_o    = 1'b0;
    pc_sel_o   = PC_PLUS4;

    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!dec_legal) begin
          trap_d  = 1'b1;
          class_d = CL_NONE;
          state_d = ST_HALT;
        end else begin
          class_d = dec_class;
          if (dec_class == CL_FENCE) begin
            // FENCE has no ordering work in this core; retire it as a NOP
            pc_we_o  = 1'b1;
            pc_sel_o = PC_PLUS4;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_EXECUTE;
          end
        end
      end

      ST_EXECUTE: begin
        case (class_q)
          CL_BRANCH: begin
            pc_we_o  = 1'b1;
            pc_sel_o = branch_taken_i ? PC_IMM : PC_PLUS4;
            state_d  = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEMORY;
          default:           state_d = ST_WRITEBACK;
        endcase
      end

      ST_MEMORY: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (class_q == CL_STORE);
        if (dmem_ready_i) begin
          if (class_q == CL_STORE) begin
            pc_we_o  = 1'b1;
            pc_sel_o = PC_PLUS4;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end

      ST_WRITEBACK: begin
        rf_we_o = 1'b1;
        pc_we_o = 1'b1;
        case (class_q)
          CL_LOAD:          wb_sel_o = WB_LOAD;
          CL_JAL, CL_JALR:  wb_sel_o = WB_PC4;
          CL_LUI:           wb_sel_o = WB_UIMM;
          default:          wb_sel_o = WB_ALU;
        endcase
        case (class_q)
          CL_JAL:  pc_sel_o = PC_IMM;
          CL_JALR: pc_sel_o = PC_ALU;
          default: pc_sel_o = PC_PLUS4;
        endcase
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        // Only reset leaves HALT; every strobe stays low
        state_d = ST_HALT;
      end

      default: begin
        // Unused encodings fall back to a fresh fetch
        state_d = ST_FETCH;
      end
    endcase
  end

  // ALU operand and immediate selects, held from EXECUTE through WRITEBACK
  always_comb begin
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    imm_sel_o   = IMM_I;
    if ((state_q == ST_EXECUTE) || (state_q == ST_MEMORY) ||
        (state_q == ST_WRITEBACK)) begin
      case (class_q)
        CL_OPIMM, CL_LOAD, CL_JALR: begin
          alu_src_b_o = 1'b1;
          imm_sel_o   = IMM_I;
        end
        CL_STORE: begin
          alu_src_b_o = 1'b1;
          imm_sel_o   = IMM_S;
        end
        CL_AUIPC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 1'b1;
          imm_sel_o   = IMM_U;
        end
        CL_BRANCH: imm_sel_o = IMM_B;
        CL_JAL:    imm_sel_o = IMM_J;
        CL_LUI:    imm_sel_o = IMM_U;
        default: begin
          alu_src_a_o = 1'b0;
          alu_src_b_o = 1'b0;
          imm_sel_o   = IMM_I;
        end
      endcase
    end
  end

  // Every retirement coincides with exactly one PC write
  always_comb begin
    retired_d = retired_q;
    if (pc_we_o) begin
      retired_d = retired_q + RETIRE_W'(1);
    end
  end

  // State, class, trap and retire-count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_NONE;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  assign trap_o    = trap_q;
  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_control_unit
// Purpose  : Randomised scoreboard bench for rv_control_unit with a
//            transaction-level reference model of instruction timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_control_unit;

  localparam int RW = 4;

  localparam bit [6:0] LUI    = 7'b0110111;
  localparam bit [6:0] AUIPC  = 7'b0010111;
  localparam bit [6:0] JAL    = 7'b1101111;
  localparam bit [6:0] JALR   = 7'b1100111;
  localparam bit [6:0] BRANCH = 7'b1100011;
  localparam bit [6:0] LOAD   = 7'b0000011;
  localparam bit [6:0] STORE  = 7'b0100011;
  localparam bit [6:0] OPIMM  = 7'b0010011;
  localparam bit [6:0] OP     = 7'b0110011;
  localparam bit [6:0] FENCE  = 7'b0001111;

  logic          clk, rst_i;
  logic [6:0]    opcode_i;
  logic [2:0]    funct3_i;
  logic          branch_taken_i, imem_ready_i, dmem_ready_i;
  logic          imem_req_o, ir_we_o, dmem_req_o, dmem_we_o;
  logic          alu_src_a_o, alu_src_b_o, rf_we_o, pc_we_o, trap_o;
  logic [2:0]    imm_sel_o, state_o;
  logic [1:0]    wb_sel_o, pc_sel_o;
  logic [RW-1:0] retired_o;

  rv_control_unit #(.RETIRE_W(RW)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .branch_taken_i(branch_taken_i), .imem_req_o(imem_req_o),
    .imem_ready_i(imem_ready_i), .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .imm_sel_o(imm_sel_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .trap_o(trap_o),
    .state_o(state_o), .retired_o(retired_o)
  );

  typedef struct {
    bit is_trap;
    int cycles;
    int pc_sel;
    bit rf;
    int wb;
    bit dwe;
    int dreq;
    int a;
    int b;
    int imm;
    int retired;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model, from the instruction rules ----------------
  function automatic bit legal(input bit [6:0] op, input int f3);
    case (op)
      LUI, AUIPC, JAL, OPIMM, OP, FENCE: return 1'b1;
      BRANCH: return (f3 != 2) && (f3 != 3);
      LOAD:   return !((f3 == 3) || (f3 >= 6));
      STORE:  return f3 < 3;
      JALR:   return f3 == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input bit [6:0] op, input int f3, input int iw,
                                 input int dw, input bit bt);
    exp_t e;
    bit   mem;
    e = '{default: 0};
    mem = (op == LOAD) || (op == STORE);
    if (!legal(op, f3)) begin
      e.is_trap = 1'b1;
      e.cycles  = iw + 3;   // fetch, decode, then the first HALT cycle
      return e;
    end
    case (op)
      LOAD:   e.cycles = 5;
      BRANCH: e.cycles = 3;
      FENCE:  e.cycles = 2;
      default: e.cycles = 4;
    endcase
    e.cycles += iw + (mem ? dw : 0);
    e.dreq    = mem ? dw + 1 : 0;
    e.dwe     = (op == STORE);
    e.rf      = !((op == BRANCH) || (op == STORE) || (op == FENCE));
    e.wb      = (op == LOAD) ? 1 : ((op == JAL) || (op == JALR)) ? 2 : (op == LUI) ? 3 : 0;
    e.pc_sel  = (op == BRANCH) ? (bt ? 1 : 0) : (op == JAL) ? 1 : (op == JALR) ? 2 : 0;
    e.a       = (op == AUIPC) ? 1 : 0;
    e.b       = ((op == OPIMM) || (op == LOAD) || (op == JALR) ||
                 (op == STORE) || (op == AUIPC)) ? 1 : 0;
    e.imm     = (op == STORE) ? 1 : (op == BRANCH) ? 2 :
                ((op == AUIPC) || (op == LUI)) ? 3 : (op == JAL) ? 4 : 0;
    e.retired = model_cnt;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0, n_ir = 0, n_dreq = 0, wb_seen = 0;
  bit saw_rf = 0, saw_dwe = 0, trap_prev = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      cyc = 0; n_ir = 0; n_dreq = 0; wb_seen = 0;
      saw_rf = 0; saw_dwe = 0; trap_prev = 0;
    end else begin
      cyc++;
      if (ir_we_o) begin
        n_ir++;
        chk("ir_we_in_fetch", {29'd0, state_o}, 32'd0);
      end
      if (dmem_req_o) begin
        n_dreq++;
        if (dmem_we_o) saw_dwe = 1;
      end
      if (rf_we_o) begin
        saw_rf  = 1;
        wb_seen = int'(wb_sel_o);
        chk("rf_we_in_writeback", {29'd0, state_o}, 32'd4);
      end
      if (state_o == 3'd2 && q.size() > 0) begin
        chk("alu_src_a", {31'd0, alu_src_a_o}, q[0].a);
        chk("alu_src_b", {31'd0, alu_src_b_o}, q[0].b);
        chk("imm_sel", {29'd0, imm_sel_o}, q[0].imm);
      end
      if (state_o == 3'd7) begin
        chk("halt_strobes", {26'd0, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o,
                             rf_we_o, pc_we_o}, 32'd0);
        chk("halt_trap", {31'd0, trap_o}, 32'd1);
      end
      if (pc_we_o) begin
        if (q.size() == 0) begin
          chk("unexpected_pc_we", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("retire_not_trap", {31'd0, e.is_trap}, 32'd0);
          chk("latency", cyc, e.cycles);
          chk("pc_sel", {30'd0, pc_sel_o}, e.pc_sel);
          chk("rf_we_seen", {31'd0, saw_rf}, {31'd0, e.rf});
          if (e.rf) chk("wb_sel", wb_seen, e.wb);
          chk("dmem_we_seen", {31'd0, saw_dwe}, {31'd0, e.dwe});
          chk("dmem_req_cycles", n_dreq, e.dreq);
          chk("ir_we_pulses", n_ir, 32'd1);
          chk("retired_before", {28'd0, retired_o}, e.retired);
        end
        cyc = 0; n_ir = 0; n_dreq = 0; wb_seen = 0; saw_rf = 0; saw_dwe = 0;
      end
      if (trap_o && !trap_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_trap", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("trap_expected", {31'd0, e.is_trap}, 32'd1);
          chk("trap_latency", cyc, e.cycles);
        end
      end
      trap_prev = trap_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst_i = 1'b1; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    step();
    rst_i = 1'b0;
    q.delete();
    model_cnt = 0;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req_o}, 32'd1);
    chk("rst_strobes", {27'd0, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o}, 32'd0);
    chk("rst_selects", {24'd0, alu_src_a_o, alu_src_b_o, imm_sel_o, wb_sel_o, pc_sel_o}, 32'd0);
    chk("rst_trap", {31'd0, trap_o}, 32'd0);
    chk("rst_retired", {28'd0, retired_o}, 32'd0);
  endtask

  task automatic wait_state(input int s);
    int k = 0;
    while (state_o != s[2:0] && k < 40) begin
      imem_ready_i = 1'($urandom % 2);
      dmem_ready_i = 1'($urandom % 2);
      step();
      k++;
    end
    if (k >= 40) chk("wait_state_timeout", {29'd0, state_o}, s);
  endtask

  task automatic run_instr(input bit [6:0] op, input int f3, input int iw,
                           input int dw, input bit bt, input bit mid_reset);
    exp_t e;
    bit   lg, mem;
    opcode_i = op; funct3_i = 3'(f3); branch_taken_i = bt;
    lg  = legal(op, f3);
    mem = (op == LOAD) || (op == STORE);
    e = model(op, f3, iw, dw, bt);
    q.push_back(e);
    if (lg && !(mid_reset && mem)) model_cnt = (model_cnt + 1) % (1 << RW);
    repeat (iw) begin
      imem_ready_i = 1'b0; dmem_ready_i = 1'($urandom % 2);
      step();
    end
    imem_ready_i = 1'b1; dmem_ready_i = 1'($urandom % 2);
    step();
    imem_ready_i = 1'b0;
    if (!lg) begin
      wait_state(7);
      repeat (12) begin
        imem_ready_i = 1'($urandom % 2); dmem_ready_i = 1'($urandom % 2);
        step();
      end
      do_reset();
      return;
    end
    if (mem) begin
      wait_state(3);
      if (mid_reset) begin
        do_reset();
        return;
      end
      repeat (dw) begin
        dmem_ready_i = 1'b0; imem_ready_i = 1'($urandom % 2);
        step();
      end
      dmem_ready_i = 1'b1;
      step();
      dmem_ready_i = 1'b0;
    end
    wait_state(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [6:0] legal_ops [10];
    bit [6:0] bad_ops [4];
    int       start;
    legal_ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE};
    bad_ops   = '{7'b0000000, 7'b1110011, 7'b1111111, 7'b0110110};
    rst_i = 1'b1; opcode_i = '0; funct3_i = '0; branch_taken_i = 1'b0;
    imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    step();
    do_reset();

    run_instr(OP, 0, 0, 0, 1'b0, 1'b0);
    chk("retired_after_op", {28'd0, retired_o}, 32'd1);
    run_instr(LOAD, 2, 0, 3, 1'b0, 1'b0);
    run_instr(BRANCH, 0, 0, 0, 1'b1, 1'b0);
    run_instr(BRANCH, 1, 0, 0, 1'b0, 1'b0);
    start = model_cnt;
    for (int i = 0; i < 16; i++) run_instr(FENCE, i % 8, 0, 0, 1'b0, 1'b0);
    chk("fence_wrap", {28'd0, retired_o}, start);
    run_instr(STORE, 2, 0, 2, 1'b0, 1'b1);
    run_instr(STORE, 1, 1, 0, 1'b0, 1'b0);
    run_instr(JALR, 1, 0, 0, 1'b0, 1'b0);
    run_instr(JALR, 0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      bit [6:0] op;
      int f3, sel;
      sel = int'($urandom % 12);
      op  = (sel < 10) ? legal_ops[sel] : (sel == 10) ? bad_ops[$urandom % 4]
                                                      : legal_ops[$urandom % 10];
      f3  = ($urandom % 2) ? 0 : int'($urandom % 8);
      run_instr(op, f3, int'($urandom % 3), int'($urandom % 4),
                1'($urandom % 2), 1'b0);
    end
    step();
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_control_unit.md
# rv_control_unit

Multi-cycle sequencer for the RV32I softcore. It steps each instruction through fetch, decode, execute, memory and writeback. It classifies the opcode/funct3 fields produced by the instruction decoder and drives the control strobes and selects for the instruction register, PC, ALU operand muxes, data memory and register file. It also handshakes with instruction and data memory, traps on illegal encodings, and counts retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `opcode_i`  in  7  opcode field from the instruction decoder.
- `funct3_i`  in  3  funct3 field from the instruction decoder.
- `branch_taken_i`  in  1  branch compare result from the ALU, valid in EXECUTE.
- `imem_req_o`  out  1  instruction fetch request.
- `imem_ready_i`  in  1  fetch complete; instruction valid.
- `ir_we_o`  out  1  instruction register load strobe.
- `dmem_req_o`  out  1  data memory request.
- `dmem_we_o`  out  1  data memory write qualifier (stores).
- `dmem_ready_i`  in  1  data access complete.
- `alu_src_a_o`  out  1  ALU operand A select: 0 = rs1, 1 = PC.
- `alu_src_b_o`  out  1  ALU operand B select: 0 = rs2, 1 = immediate.
- `imm_sel_o`  out  3  immediate select: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `rf_we_o`  out  1  register file write strobe.
- `wb_sel_o`  out  2  writeback source: 00 = ALU, 01 = load data, 10 = PC+4, 11 = U-immediate.
- `pc_we_o`  out  1  PC update strobe.
- `pc_sel_o`  out  2  next-PC source: 00 = PC+4, 01 = PC+imm, 10 = {alu[31:1],1'b0}.
- `trap_o`  out  1  sticky illegal-instruction flag.
- `state_o`  out  3  current state, for debug.
- `retired_o`  out  RETIRE_W  count of retired instructions.

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, HALT = 7.
- FETCH: `imem_req_o` = 1.
  - When `imem_ready_i` = 1: `ir_we_o` = 1 in the same cycle (Mealy), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify `opcode_i` and latch the class into an internal register. Later states use only the latched class.
  - Legal classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, FENCE 0001111.
  - Illegal encodings:
    - any other opcode;
    - BRANCH with funct3 010 or 011;
    - LOAD with funct3 011, 110 or 111;
    - STORE with funct3 ≥ 011;
    - JALR with funct3 ≠ 000.
  - Illegal → HALT, set `trap_o`.
  - FENCE is a NOP: `pc_we_o` = 1, `pc_sel_o` = 00, retire, go to FETCH.
  - All other legal classes → EXECUTE.
- EXECUTE, operand selects by class:
  - OP: B = rs2.
  - OPIMM, LOAD, JALR: B = imm, I-type.
  - STORE: B = imm, S-type.
  - AUIPC: A = PC, B = imm, U-type.
  - BRANCH: B = rs2, `imm_sel_o` = B-type.
  - JAL: `imm_sel_o` = J-type.
  - LUI: `imm_sel_o` = U-type.
  - Unused selects are driven to 0.
- Transitions out of EXECUTE:
  - BRANCH: `pc_we_o` = 1, `pc_sel_o` = `branch_taken_i` ? 01 : 00, retire, go to FETCH.
  - LOAD, STORE: go to MEMORY.
  - All others: go to WRITEBACK.
- MEMORY: `dmem_req_o` = 1, `dmem_we_o` = 1 for STORE only. Selects are held at their EXECUTE values.
  - On `dmem_ready_i` = 1, STORE: `pc_we_o` = 1, `pc_sel_o` = 00, retire, go to FETCH.
  - On `dmem_ready_i` = 1, LOAD: go to WRITEBACK.
- WRITEBACK: `rf_we_o` = 1 and `pc_we_o` = 1 in the same cycle, then retire and go to FETCH.
  - `wb_sel_o`: LOAD 01, JAL/JALR 10, LUI 11, else 00.
  - `pc_sel_o`: JAL 01, JALR 10, else 00.
- HALT: all strobes and requests are 0. Only `rst_i` exits HALT.
- Retire: `retired_o` increments by 1 and wraps modulo 2^RETIRE_W.

## Timing
- Reset (synchronous, `rst_i` sampled high):
  - state = FETCH, latched class = 0, `retired_o` = 0, `trap_o` = 0.
  - `imem_req_o` is 1 in the first cycle after reset release.
  - All other outputs are 0.
- Reset mid-operation (any state, including a pending memory request): the request drops on the next edge. No completion is owed to memory. `retired_o` clears.
- Handshake rules:
  - A request is held high until ready is sampled high. There is no timeout.
  - Ready sampled while the corresponding request is low is ignored.
  - The request deasserts in the cycle after ready.
- Latency with zero-wait memory (ready high in the first request cycle):
  - OP, OPIMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - FENCE: 2 cycles.
  - Each wait cycle on a memory port adds 1.
- `pc_we_o`, `rf_we_o` and `ir_we_o` are single-cycle pulses. At most one PC write occurs per instruction.
- Simultaneous `imem_ready_i` and `dmem_ready_i`: only the port whose request is active is honoured.

## Test plan
- Reset, then OP (0110011) with zero-wait fetch:
  - states 0→1→2→4→0;
  - `rf_we_o` = 1 and `wb_sel_o` = 00 in cycle 3;
  - `retired_o` = 1.
- LOAD (funct3 010) with `dmem_ready_i` delayed 3 cycles:
  - `dmem_req_o` high for 4 cycles and `dmem_we_o` = 0;
  - WRITEBACK with `wb_sel_o` = 01;
  - total 8 cycles.
- BRANCH with `branch_taken_i` = 1, then `branch_taken_i` = 0:
  - `pc_sel_o` = 01, then 00, both in EXECUTE;
  - `rf_we_o` never asserted;
  - 3 cycles each.
- JALR funct3 001, then reset:
  - HALT with `trap_o` = 1 and all strobes 0 for 10+ cycles;
  - `rst_i` clears `trap_o` and restarts FETCH.
- `rst_i` asserted while in MEMORY on a STORE with `dmem_ready_i` = 0: `dmem_req_o` = 0 and state = 0 the next cycle.
- With `RETIRE_W` = 4, retire 16 FENCE instructions: `retired_o` wraps 15→0, with one `pc_we_o` pulse per FENCE.
